// File: rtl/boreal_pkg.sv
// Shared types and constants for the boreal gate arbiter.
package boreal_pkg;

    localparam int REQ_W = 256;
    localparam int ARB_DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/boreal_rr_picker.sv
// Round-robin picker: first eligible channel after last_grant, wrapping.
module boreal_rr_picker #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0] mask,
    input  logic [2:0]      last_grant,
    output logic            found,
    output logic [2:0]      idx
);

    logic [7:0] m8;
    logic [3:0] pos;

    assign m8 = 8'(mask);

    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        pos   = 4'd0;
        for (int k = 1; k <= N_CH; k++) begin
            pos = {1'b0, last_grant} + 4'(k);
            if (pos >= 4'(N_CH)) pos = pos - 4'(N_CH);
            if (!found && m8[pos[2:0]]) begin
                found = 1'b1;
                idx   = pos[2:0];
            end
        end
    end

endmodule

// File: rtl/boreal_gate_arbiter.sv
// Shares one policy gate between N_CH mailbox channels with a
// round-robin grant and a watchdog abort.
module boreal_gate_arbiter
    import boreal_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int TIMEOUT = ARB_DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       ch_enable,
    input  logic [N_CH-1:0]       ch_req_valid,
    input  logic [N_CH*REQ_W-1:0] ch_req_words,
    output logic [N_CH-1:0]       ch_req_consume,
    output logic [N_CH-1:0]       ch_resp_we,
    output logic [2:0]            ch_resp_widx,
    output logic [31:0]           ch_resp_wdata,
    output logic [N_CH-1:0]       ch_resp_valid_set,
    output logic                  g_req_valid,
    output logic [REQ_W-1:0]      g_req_words,
    input  logic                  g_req_consume,
    input  logic                  g_resp_we,
    input  logic [2:0]            g_resp_widx,
    input  logic [31:0]           g_resp_wdata,
    input  logic                  g_resp_valid_set,
    output logic                  busy,
    output logic [2:0]            grant_id,
    output logic                  timeout_pulse
);

    arb_state_t       state;
    logic [REQ_W-1:0] req_q;
    logic [2:0]       last_grant;
    logic [15:0]      wd;

    logic [N_CH-1:0]  elig;
    logic [N_CH-1:0]  gsel;
    logic             found;
    logic [2:0]       pick;
    logic [REQ_W-1:0] pick_words;

    logic in_issue;
    logic in_wait;
    logic wd_hit;
    logic take;
    logic done;
    logic abort;

    assign elig = ch_req_valid & ch_enable;

    boreal_rr_picker #(
        .N_CH(N_CH)
    ) u_picker (
        .mask       (elig),
        .last_grant (last_grant),
        .found      (found),
        .idx        (pick)
    );

    always_comb begin
        pick_words = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (pick == 3'(i)) pick_words = ch_req_words[i*REQ_W +: REQ_W];
        end
    end

    always_comb begin
        gsel = '0;
        for (int i = 0; i < N_CH; i++) begin
            gsel[i] = (grant_id == 3'(i));
        end
    end

    // Reset masks every combinational pulse so none escapes in the reset cycle.
    assign in_issue = rst_n && (state == ARB_ISSUE);
    assign in_wait  = rst_n && (state == ARB_WAIT);
    assign wd_hit   = (wd == 16'(TIMEOUT - 1));
    assign take     = in_issue && g_req_consume;
    assign done     = in_wait && g_resp_valid_set;
    assign abort    = (in_issue || in_wait) && wd_hit && !take && !done;

    assign ch_req_consume    = gsel & {N_CH{take || (abort && in_issue)}};
    assign ch_resp_we        = gsel & {N_CH{in_wait && g_resp_we}};
    assign ch_resp_valid_set = gsel & {N_CH{done}};
    assign ch_resp_widx      = in_wait ? g_resp_widx : 3'd0;
    assign ch_resp_wdata     = in_wait ? g_resp_wdata : 32'd0;

    assign timeout_pulse = abort;
    assign busy          = (state != ARB_IDLE);
    assign g_req_words   = req_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            req_q       <= '0;
            grant_id    <= 3'd0;
            last_grant  <= 3'(N_CH - 1);
            wd          <= 16'd0;
            g_req_valid <= 1'b0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (found) begin
                        state       <= ARB_ISSUE;
                        req_q       <= pick_words;
                        grant_id    <= pick;
                        g_req_valid <= 1'b1;
                        wd          <= 16'd0;
                    end
                end
                ARB_ISSUE, ARB_WAIT: begin
                    wd <= wd + 16'd1;
                    if (take) begin
                        state       <= ARB_WAIT;
                        g_req_valid <= 1'b0;
                    end else if (done) begin
                        state      <= ARB_IDLE;
                        last_grant <= grant_id;
                    end else if (abort) begin
                        state       <= ARB_IDLE;
                        g_req_valid <= 1'b0;
                        last_grant  <= grant_id;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
